// File: rtl/vp_pkg.sv
// rtl/vp_pkg.sv - shared types for the value-predictor update scheduler
package vp_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } vp_state_e;

   localparam int VP_IDX_W  = 10;
   localparam int VP_DATA_W = 72;

   // Default-width view of one training update; the scheduler builds the same shape from its parameters.
   typedef struct packed {
      logic [VP_IDX_W-1:0]  idx;
      logic [VP_DATA_W-1:0] data;
   } vp_update_t;

endpackage

// File: rtl/vp_update_fifo.sv
// rtl/vp_update_fifo.sv - multi-push, single-pop circular update buffer with flush
module vp_update_fifo #(
   parameter int P_LANES = 2,
   parameter int P_W     = 82,
   parameter int P_DEPTH = 8,
   parameter int P_OCC_W = $clog2(P_DEPTH) + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic [P_LANES-1:0]     push_i,
   input  logic [P_LANES*P_W-1:0] push_data_i,
   input  logic                   pop_i,
   output logic [P_W-1:0]         head_o,
   output logic [P_OCC_W-1:0]     occ_o
);

   localparam int AW = $clog2(P_DEPTH);

   logic [P_W-1:0]     mem_q [P_DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [P_OCC_W-1:0] occ_q, occ_d;
   logic [P_OCC_W-1:0] n_push;
   logic [AW-1:0]      slot [P_LANES];

   // Valid lanes are packed densely: each lane lands after the lower lanes that actually push.
   always_comb begin
      n_push = '0;
      for (int k = 0; k < P_LANES; k++) begin
         slot[k] = wr_ptr_q + n_push[AW-1:0];
         if (push_i[k]) begin
            n_push = n_push + P_OCC_W'(1);
         end
      end
      wr_ptr_d = wr_ptr_q + n_push[AW-1:0];
      rd_ptr_d = rd_ptr_q + AW'(pop_i);
      occ_d    = occ_q + n_push - P_OCC_W'(pop_i);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         if (!flush_i) begin
            for (int k = 0; k < P_LANES; k++) begin
               if (push_i[k]) begin
                  mem_q[slot[k]] <= push_data_i[k*P_W +: P_W];
               end
            end
         end
      end
   end

   assign head_o = mem_q[rd_ptr_q];
   assign occ_o  = occ_q;

endmodule

// File: rtl/vp_update_sched.sv
// rtl/vp_update_sched.sv - value-predictor table write-port scheduler: clear sequence and in-order update drain
module vp_update_sched
   import vp_pkg::*;
#(
   parameter int P_NUM_PRED   = 2,
   parameter int P_IDX_W      = 10,
   parameter int P_DATA_W     = 72,
   parameter int P_FIFO_DEPTH = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [P_NUM_PRED-1:0]          up_valid_i,
   output logic [P_NUM_PRED-1:0]          up_ready_o,
   input  logic [P_NUM_PRED*P_IDX_W-1:0]  up_idx_i,
   input  logic [P_NUM_PRED*P_DATA_W-1:0] up_data_i,
   input  logic                           clear_i,
   input  logic                           tbl_stall_i,
   output logic                           tbl_we_o,
   output logic [P_IDX_W-1:0]             tbl_idx_o,
   output logic [P_DATA_W-1:0]            tbl_data_o,
   output logic                           busy_o,
   output logic [$clog2(P_FIFO_DEPTH):0]  occ_o
);

   localparam int OCC_W = $clog2(P_FIFO_DEPTH) + 1;
   localparam int UPD_W = P_IDX_W + P_DATA_W;
   localparam logic [OCC_W-1:0]   DEPTH_C  = OCC_W'(P_FIFO_DEPTH);
   localparam logic [OCC_W-1:0]   LANES_C  = OCC_W'(P_NUM_PRED);
   localparam logic [P_IDX_W-1:0] LAST_IDX = '1;

   typedef struct packed {
      logic [P_IDX_W-1:0]  idx;
      logic [P_DATA_W-1:0] data;
   } upd_t;

   vp_state_e                   state_q, state_d;
   logic [P_IDX_W-1:0]          cnt_q, cnt_d;
   logic                        ready;
   logic                        pop;
   logic                        flush;
   logic [P_NUM_PRED-1:0]       push;
   logic [P_NUM_PRED*UPD_W-1:0] push_data;
   logic [UPD_W-1:0]            head_raw;
   upd_t                        head;
   logic [OCC_W-1:0]            occ;

   always_comb begin
      push_data = '0;
      for (int k = 0; k < P_NUM_PRED; k++) begin
         push_data[k*UPD_W +: UPD_W] = {up_idx_i[k*P_IDX_W +: P_IDX_W],
                                        up_data_i[k*P_DATA_W +: P_DATA_W]};
      end
   end

   assign head       = upd_t'(head_raw);
   assign up_ready_o = {P_NUM_PRED{ready}};
   assign push       = up_valid_i & up_ready_o & {P_NUM_PRED{!clear_i}};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ready      = 1'b0;
      busy_o     = 1'b0;
      tbl_we_o   = 1'b0;
      tbl_idx_o  = '0;
      tbl_data_o = '0;
      pop        = 1'b0;
      flush      = 1'b0;
      case (state_q)
         CLEAR: begin
            busy_o    = 1'b1;
            tbl_we_o  = !tbl_stall_i;
            tbl_idx_o = cnt_q;
            if (clear_i) begin
               cnt_d = '0;
            end else if (!tbl_stall_i) begin
               cnt_d = cnt_q + P_IDX_W'(1);
               if (cnt_q == LAST_IDX) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Ready uses registered occupancy only, so a full buffer cannot overflow even if nothing pops.
            ready      = (DEPTH_C - occ) >= LANES_C;
            // A clear discards the head too, so it must not reach the table in that cycle.
            tbl_we_o   = (occ != '0) && !tbl_stall_i && !clear_i;
            tbl_idx_o  = head.idx;
            tbl_data_o = head.data;
            pop        = tbl_we_o;
            if (clear_i) begin
               flush   = 1'b1;
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   vp_update_fifo #(
      .P_LANES (P_NUM_PRED),
      .P_W     (UPD_W),
      .P_DEPTH (P_FIFO_DEPTH),
      .P_OCC_W (OCC_W)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head_raw),
      .occ_o       (occ)
   );

   assign occ_o = occ;

endmodule
